// File: rtl/cnt_ctrl_pkg.sv
// Shared types and helpers for the parity counter sequencer.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Bit 1 selects direction (1 = down), bit 0 selects parity (1 = even).
  typedef enum logic [1:0] {
    ModeOddUp    = 2'b00,
    ModeEvenUp   = 2'b01,
    ModeOddDown  = 2'b10,
    ModeEvenDown = 2'b11
  } mode_e;

  // First sample of a job for a w-bit counter; caller truncates to its width.
  function automatic logic [63:0] start_val(mode_e mode, int unsigned w);
    logic [63:0] all_ones;
    logic [63:0] val;
    all_ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (mode)
      ModeOddUp:    val = 64'd1;
      ModeEvenUp:   val = 64'd0;
      ModeOddDown:  val = all_ones;
      default:      val = all_ones - 64'd1;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/parity_step_counter.sv
// W-bit counter stepping by +/-2 with a load port and a carry/borrow flag.
module parity_step_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         step_i,
  input  logic         down_i,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);

  logic [W-1:0] value_q, value_d;
  logic         wrap_q, wrap_d;
  logic [W:0]   sum;

  // Next value; the extra top bit is the carry (up) or borrow (down).
  always_comb begin
    sum     = down_i ? ({1'b0, value_q} - (W+1)'(2)) : ({1'b0, value_q} + (W+1)'(2));
    value_d = value_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      value_d = load_val_i;
    end else if (step_i) begin
      value_d = sum[W-1:0];
      wrap_d  = sum[W];
    end
  end

  // Value and wrap flag registers; wrap only reflects the most recent step.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign value_o = value_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Command-driven sequencer: accepts a counting job, emits len samples, pulses done.
module count_seq_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_mode_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [W-1:0]     cnt_o,
  output logic             cnt_valid_o,
  output logic             wrap_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             down_q, down_d;
  logic             valid_q, valid_d;
  logic             load, step;
  logic [W-1:0]     start_w;

  assign start_w = W'(start_val(mode_e'(cmd_mode_i), W));

  // Next-state logic: abort beats pause, pause beats step.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    down_d  = down_q;
    valid_d = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          down_d = cmd_mode_i[1];
          if (cmd_len_i != '0) begin
            load    = 1'b1;
            rem_d   = cmd_len_i - LEN_W'(1);
            valid_d = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (!pause_i) begin
          if (rem_q != '0) begin
            step    = 1'b1;
            rem_d   = rem_q - LEN_W'(1);
            valid_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, remaining count, latched direction and sample-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      down_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      down_q  <= down_d;
      valid_q <= valid_d;
    end
  end

  parity_step_counter #(
    .W (W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (start_w),
    .step_i     (step),
    .down_i     (down_q),
    .value_o    (cnt_o),
    .wrap_o     (wrap_o)
  );

  assign cnt_valid_o = valid_q;
  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: directed scenarios plus random jobs.
module tb_count_seq_ctrl;

  localparam int W     = 8;
  localparam int LEN_W = 8;
  localparam int MOD   = 1 << W;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [1:0]       cmd_mode_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             pause_i;
  logic             abort_i;
  logic [W-1:0]     cnt_o;
  logic             cnt_valid_o;
  logic             wrap_o;
  logic             busy_o;
  logic             done_o;

  int n_cmp = 0;
  int n_err = 0;

  count_seq_ctrl #(
    .W     (W),
    .LEN_W (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_mode_i  (cmd_mode_i),
    .cmd_len_i   (cmd_len_i),
    .pause_i     (pause_i),
    .abort_i     (abort_i),
    .cnt_o       (cnt_o),
    .cnt_valid_o (cnt_valid_o),
    .wrap_o      (wrap_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k-th sample of a job as plain modular arithmetic on the unwrapped sequence.
  function automatic int exp_val(input logic [1:0] m, input int k);
    int s;
    int v;
    if (m[1]) s = m[0] ? MOD - 2 : MOD - 1;
    else      s = m[0] ? 0 : 1;
    v = m[1] ? s - 2 * k : s + 2 * k;
    v = v % MOD;
    if (v < 0) v += MOD;
    return v;
  endfunction

  // A sample wraps when its step left the range [0, MOD-1].
  function automatic logic exp_wrap(input logic [1:0] m, input int k);
    int p;
    if (k == 0) return 1'b0;
    p = exp_val(m, k - 1);
    return m[1] ? (p - 2 < 0) : (p + 2 > MOD - 1);
  endfunction

  // Runs one job from IDLE and checks every cycle until IDLE again.
  task automatic run_job(input logic [1:0] m, input int len, input int pause_idx,
                         input int pause_n, input bit rnd_pause, input int abort_idx,
                         input bit abort_on_accept);
    int k;
    int np;
    int last;
    chk("idle_ready", 32'(cmd_ready_o), 1);
    chk("idle_busy", 32'(busy_o), 0);
    cmd_valid_i = 1'b1;
    cmd_mode_i  = m;
    cmd_len_i   = LEN_W'(len);
    abort_i     = abort_on_accept;
    tick();
    abort_i = 1'b0;
    // Junk command held during the job must be ignored.
    cmd_mode_i  = 2'($urandom);
    cmd_len_i   = LEN_W'($urandom);
    cmd_valid_i = 1'($urandom_range(0, 1));
    if (len == 0) begin
      chk("empty_done", 32'(done_o), 1);
      chk("empty_valid", 32'(cnt_valid_o), 0);
      chk("empty_busy", 32'(busy_o), 1);
      tick();
      cmd_valid_i = 1'b0;
      chk("empty_done_after", 32'(done_o), 0);
      chk("empty_ready_after", 32'(cmd_ready_o), 1);
      return;
    end
    k    = 0;
    last = 0;
    while (1) begin
      chk("sample_valid", 32'(cnt_valid_o), 1);
      chk("sample_cnt", 32'(cnt_o), 32'(exp_val(m, k)));
      chk("sample_wrap", 32'(wrap_o), 32'(exp_wrap(m, k)));
      chk("sample_done", 32'(done_o), 0);
      last = exp_val(m, k);
      if (k == abort_idx) begin
        abort_i = 1'b1;
        tick();
        abort_i     = 1'b0;
        cmd_valid_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_valid", 32'(cnt_valid_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_wrap", 32'(wrap_o), 0);
        chk("abort_cnt", 32'(cnt_o), 32'(last));
        chk("abort_ready", 32'(cmd_ready_o), 1);
        return;
      end
      np = (k == pause_idx) ? pause_n : (rnd_pause ? int'($urandom_range(0, 2)) : 0);
      for (int i = 0; i < np; i++) begin
        pause_i = 1'b1;
        tick();
        chk("pause_valid", 32'(cnt_valid_o), 0);
        chk("pause_wrap", 32'(wrap_o), 0);
        chk("pause_done", 32'(done_o), 0);
        chk("pause_busy", 32'(busy_o), 1);
        chk("pause_cnt", 32'(cnt_o), 32'(last));
      end
      pause_i = 1'b0;
      tick();
      if (k == len - 1) break;
      k++;
    end
    chk("done_pulse", 32'(done_o), 1);
    chk("done_valid", 32'(cnt_valid_o), 0);
    chk("done_wrap", 32'(wrap_o), 0);
    chk("done_cnt", 32'(cnt_o), 32'(last));
    chk("done_busy", 32'(busy_o), 1);
    tick();
    cmd_valid_i = 1'b0;
    chk("post_done", 32'(done_o), 0);
    chk("post_busy", 32'(busy_o), 0);
    chk("post_ready", 32'(cmd_ready_o), 1);
    chk("post_cnt", 32'(cnt_o), 32'(last));
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_mode_i  = 2'b00;
    cmd_len_i   = '0;
    pause_i     = 1'b0;
    abort_i     = 1'b0;

    // Reset held for two edges.
    tick();
    tick();
    chk("rst_cnt", 32'(cnt_o), 0);
    chk("rst_valid", 32'(cnt_valid_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_wrap", 32'(wrap_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(cmd_ready_o), 1);

    // Odd-up short job.
    run_job(2'b00, 4, -1, 0, 1'b0, -1, 1'b0);
    // Odd-up across the wrap.
    run_job(2'b00, 130, -1, 0, 1'b0, -1, 1'b0);
    // Even-down with a two-cycle pause after the first sample.
    run_job(2'b11, 3, 0, 2, 1'b0, -1, 1'b0);
    // Even-up aborted on the sample showing 4, then an immediate new job.
    run_job(2'b01, 10, -1, 0, 1'b0, 2, 1'b0);
    run_job(2'b10, 2, -1, 0, 1'b0, -1, 1'b0);
    // Empty job; abort during accept is ignored in IDLE.
    run_job(2'b01, 0, -1, 0, 1'b0, -1, 1'b0);
    run_job(2'b11, 5, -1, 0, 1'b0, -1, 1'b1);
    // Even-down across zero.
    run_job(2'b11, 130, -1, 0, 1'b0, -1, 1'b0);

    // Reset in the middle of an odd-down job.
    cmd_valid_i = 1'b1;
    cmd_mode_i  = 2'b10;
    cmd_len_i   = LEN_W'(20);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    chk("mid_cnt_before_rst", 32'(cnt_o), 32'(MOD - 5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cnt", 32'(cnt_o), 0);
    chk("midrst_valid", 32'(cnt_valid_o), 0);
    chk("midrst_wrap", 32'(wrap_o), 0);
    chk("midrst_done", 32'(done_o), 0);
    tick();
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_ready", 32'(cmd_ready_o), 1);
    chk("midrst_done2", 32'(done_o), 0);

    // Random jobs with random pauses and occasional aborts.
    for (int j = 0; j < 24; j++) begin
      logic [1:0] m;
      int len;
      int ab;
      m   = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      ab  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_job(m, len, -1, 0, 1'b1, ab, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
